// File: rtl/isqrt_flow_ctrl.sv
// Flow control around a fixed-latency, non-stallable isqrt core.
// It tracks in-flight operands and stores their results in a FIFO. Credits limit acceptance so that every result has a FIFO slot.
module isqrt_flow_ctrl #(
  parameter int LATENCY = 16,
  parameter int DEPTH   = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  output logic [31:0] pipe_x,
  input  logic [15:0] pipe_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_y,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that transfer.
  logic               accept;
  logic               pop;
  logic               wr_en;
  logic               empty;
  logic               full;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      reserved_q, reserved_d;
  logic [15:0]        mem_q [DEPTH];

  // in_ready depends only on the registered credit count.
  assign in_ready  = reserved_q < CW'(DEPTH);
  assign accept    = in_valid & in_ready;
  assign pipe_x    = accept ? in_x : 32'd0;
  assign wr_en     = vld_q[LATENCY-1];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid = !empty;
  assign out_y     = empty ? 16'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign pop       = out_valid & out_ready;
  assign busy      = (reserved_q != '0);

  always_comb begin
    vld_d      = vld_q << 1;
    vld_d[0]   = accept;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    reserved_d = reserved_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    // A credit stays held from acceptance until its result is popped.
    case ({accept, pop})
      2'b10:   reserved_d = reserved_q + 1'b1;
      2'b01:   reserved_d = reserved_q - 1'b1;
      default: reserved_d = reserved_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      reserved_q <= '0;
    end else begin
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      reserved_q <= reserved_d;
    end
  end

  // Storage needs no reset: out_y is forced to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= pipe_y;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(wr_en && full));
  a_credit_bound: assert property (@(posedge clock) disable iff (!reset_n)
    reserved_q <= CW'(DEPTH));

endmodule

// File: tb/tb_isqrt_flow_ctrl.sv
// Bench for isqrt_flow_ctrl with a behavioural fixed-latency core stub.
// Expected results are queued on acceptance and compared as results pop.
module tb_isqrt_flow_ctrl;

  localparam int LATENCY = 16;
  localparam int DEPTH   = 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = 32'd0;
  logic [31:0] pipe_x;
  logic [15:0] pipe_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        busy;

  logic [15:0] core_q [LATENCY];
  logic [15:0] exp_q [$];
  int          or_mode = 0;
  logic        rnd_bit = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  int          base;
  int          n;
  logic        sender_done;
  logic [31:0] bx [6] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd1000000, 32'hFFFFFFFF};
  logic [15:0] by [6] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd1000, 16'hFFFF};
  logic [31:0] rr;
  logic [31:0] xx;

  isqrt_flow_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .pipe_x(pipe_x), .pipe_y(pipe_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .busy(busy)
  );

  always #5 clock = ~clock;

  assign out_ready = (or_mode == 2) ? rnd_bit : (or_mode == 1);

  always @(posedge clock) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [31:0] r;
    logic [31:0] t;
    logic [63:0] sq;
    r = 32'd0;
    for (int b = 15; b >= 0; b--) begin
      t  = r | (32'd1 << b);
      sq = {32'd0, t} * {32'd0, t};
      if (sq <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  // Core stub: non-stallable pipeline sharing reset_n with the DUT.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < LATENCY; k++) core_q[k] <= 16'd0;
    end else begin
      core_q[0] <= isqrt32(pipe_x);
      for (int k = 1; k < LATENCY; k++) core_q[k] <= core_q[k-1];
    end
  end
  assign pipe_y = core_q[LATENCY-1];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: a result transfers on the next edge when valid and ready are high at the negedge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", out_y);
      end else begin
        check("out_y", 32'(out_y), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [15:0] e, input int budget);
    int  waited;
    logic ok;
    waited   = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_x     = x;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      if (waited >= budget) begin
        checks++;
        errors++;
        $display("FAIL accept_wait: in_ready got 0 expected 1 within %0d cycles", budget);
        break;
      end
      waited++;
      @(posedge clock); #1;
    end
    if (ok) begin
      exp_q.push_back(e);
      acc_cnt++;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Waits from the start of the cycle after acceptance, with out_ready held high.
  task automatic check_latency(input string name);
    repeat (16) @(negedge clock);
    check({name, "_early_valid"}, 32'(out_valid), 32'd0);
    @(negedge clock);
    check({name, "_valid_at_17"}, 32'(out_valid), 32'd1);
    check({name, "_busy_before_pop"}, 32'(busy), 32'd1);
    @(negedge clock);
    check({name, "_valid_after_pop"}, 32'(out_valid), 32'd0);
    check({name, "_busy_after_pop"}, 32'(busy), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clock);
      k++;
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    check({name, "_busy"}, 32'(busy), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_y", 32'(out_y), 32'd0);
    check("reset_pipe_x", pipe_x, 32'd0);
    reset_n = 1'b1;
    or_mode = 1;
    @(posedge clock); #1;

    // Single operand, exact latency and busy timing.
    send(32'd16, 16'd4, 0);
    check_latency("single");

    // Back-to-back burst with a ready consumer.
    for (int i = 0; i < 6; i++) send(bx[i], by[i], 0);
    repeat (11) @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("burst_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clock);
    check("burst_end_valid", 32'(out_valid), 32'd0);
    @(posedge clock); #1;

    // Full backpressure: 40 squares offered, only DEPTH fit.
    or_mode     = 0;
    base        = acc_cnt;
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(32'(i * i), 16'(i), 400);
        sender_done = 1'b1;
      end
    join_none
    repeat (60) @(negedge clock);
    check("bp_accepted", 32'(acc_cnt - base), 32'd32);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    @(posedge clock); #1;
    or_mode = 1;
    @(negedge clock);
    check("bp_ready_at_first_pop", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    n = 0;
    while (!sender_done && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("bp_sender_done", 32'(sender_done), 32'd1);
    @(posedge clock); #1;
    drain("bp_drain");

    // Reset with 5 results stored and 10 still in the core.
    or_mode = 0;
    for (int i = 0; i < 5; i++) send(32'((100 + i) * (100 + i)), 16'(100 + i), 0);
    repeat (20) @(posedge clock);
    #1;
    check("rst_stored_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) send(32'((200 + i) * (200 + i)), 16'(200 + i), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_y", 32'(out_y), 32'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    or_mode = 1;
    n = 0;
    repeat (30) begin
      @(negedge clock);
      if (out_valid) n++;
    end
    check("rst_no_stale", 32'(n), 32'd0);
    @(posedge clock); #1;
    send(32'd49, 16'd7, 0);
    check_latency("after_reset");

    // Random consumer; operands in [r*r, r*r+2r] have root r.
    or_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      rr = 32'($urandom_range(0, 65535));
      xx = rr * rr + 32'($urandom_range(0, 32'(2) * rr));
      send(xx, rr[15:0], 1000);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end
    or_mode = 1;
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
